// File: rtl/uart8_pkg.sv
// Shared types and divider helpers for the uart8 8N1 UART.
package uart8_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitHigh
  } rx_state_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_t;

  // Receiver oversamples 16x per bit.
  function automatic int unsigned rx_div(input int unsigned clock_rate,
                                         input int unsigned baud_rate);
    return clock_rate / (baud_rate * 16);
  endfunction

  function automatic int unsigned tx_div(input int unsigned clock_rate,
                                         input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart8_baud_gen.sv
// Free-running rx (16x) and tx (1x) baud tick generators; tx divider restarts per frame.
module uart8_baud_gen #(
  parameter int unsigned RX_DIV = 78,
  parameter int unsigned TX_DIV = 1250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_restart,
  output logic rx_tick,
  output logic tx_tick
);

  localparam int unsigned RxW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int unsigned TxW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;

  logic [RxW-1:0] rx_cnt_q;
  logic [TxW-1:0] tx_cnt_q;

  assign rx_tick = (rx_cnt_q == RxW'(RX_DIV - 1));
  assign tx_tick = (tx_cnt_q == TxW'(TX_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + 1'b1;
      // Restart aligns the first tx bit boundary with the start request.
      if (tx_restart || tx_tick) tx_cnt_q <= '0;
      else                       tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart8.sv
// 8N1 UART top: synchronised 16x-oversampling receiver and a byte transmitter.
module uart8
  import uart8_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 12000000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxEn,
  input  logic       rxIn,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] rxOut,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);

  localparam int unsigned RX_DIV = rx_div(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned TX_DIV = tx_div(CLOCK_RATE, BAUD_RATE);

  logic rx_tick, tx_tick, tx_restart;

  uart8_baud_gen #(
    .RX_DIV(RX_DIV),
    .TX_DIV(TX_DIV)
  ) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_restart(tx_restart),
    .rx_tick   (rx_tick),
    .tx_tick   (tx_tick)
  );

  logic [1:0] rx_sync_q;
  logic       rx_sync;
  assign rx_sync = rx_sync_q[1];

  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_s_q, rx_s_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_out_q, rx_out_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_err_q, rx_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RxIdle;
      rx_s_q     <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_out_q   <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rxIn};
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_out_q   <= rx_out_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_out_d   = rx_out_q;
    rx_done_d  = 1'b0;
    rx_err_d   = rx_err_q;
    if (!rxEn) begin
      rx_state_d = RxIdle;
      rx_s_d     = '0;
      rx_bit_d   = '0;
    end else if (rx_tick) begin
      unique case (rx_state_q)
        RxIdle: begin
          if (!rx_sync) begin
            rx_state_d = RxStart;
            rx_s_d     = '0;
            rx_err_d   = 1'b0;
          end
        end
        // Mid-start recheck rejects glitches shorter than half a bit.
        RxStart: begin
          if (rx_s_q == 4'd7) begin
            rx_s_d     = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync ? RxIdle : RxData;
          end else begin
            rx_s_d = rx_s_q + 4'd1;
          end
        end
        RxData: begin
          rx_s_d = rx_s_q + 4'd1;
          if (rx_s_q == 4'd15) begin
            rx_shift_d = {rx_sync, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          end
        end
        RxStop: begin
          rx_s_d = rx_s_q + 4'd1;
          if (rx_s_q == 4'd15) begin
            if (rx_sync) begin
              rx_out_d   = rx_shift_q;
              rx_done_d  = 1'b1;
              rx_state_d = RxIdle;
            end else begin
              rx_err_d   = 1'b1;
              rx_state_d = RxWaitHigh;
            end
          end
        end
        RxWaitHigh: begin
          if (rx_sync) rx_state_d = RxIdle;
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  assign rxBusy = (rx_state_q == RxStart) || (rx_state_q == RxData) || (rx_state_q == RxStop);
  assign rxDone = rx_done_q;
  assign rxErr  = rx_err_q;
  assign rxOut  = rx_out_q;

  tx_state_t  tx_state_q, tx_state_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_done_q, tx_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TxIdle;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_done_d  = 1'b0;
    tx_restart = 1'b0;
    if (!txEn) begin
      tx_state_d = TxIdle;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (txStart) begin
            tx_byte_d  = txIn;
            tx_bit_d   = '0;
            tx_restart = 1'b1;
            tx_state_d = TxStart;
          end
        end
        TxStart: if (tx_tick) tx_state_d = TxData;
        TxData: begin
          if (tx_tick) begin
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          end
        end
        TxStop: begin
          if (tx_tick) begin
            tx_done_d  = 1'b1;
            tx_state_d = TxIdle;
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  always_comb begin
    txOut = 1'b1;
    if (txEn) begin
      unique case (tx_state_q)
        TxStart: txOut = 1'b0;
        TxData:  txOut = tx_byte_q[tx_bit_q];
        default: txOut = 1'b1;
      endcase
    end
  end

  assign txBusy = (tx_state_q != TxIdle);
  assign txDone = tx_done_q;

endmodule

// File: tb/tb_uart8.sv
// Bench for uart8: frame-level tx/rx model checked every cycle plus directed literal checks.
module tb_uart8;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int TxBit = 1250;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxEn, rxIn, rxBusy, rxDone, rxErr;
  logic [7:0] rxOut;
  logic       txEn, txStart, txBusy, txDone, txOut;
  logic [7:0] txIn;
  logic       loop, rx_drv;

  assign rxIn = loop ? txOut : rx_drv;

  always #5 clk = ~clk;

  uart8 #(
    .CLOCK_RATE(12000000),
    .BAUD_RATE (9600)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxEn   (rxEn),
    .rxIn   (rxIn),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .rxOut  (rxOut),
    .txEn   (txEn),
    .txStart(txStart),
    .txIn   (txIn),
    .txBusy (txBusy),
    .txDone (txDone),
    .txOut  (txOut)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame bit i of an 8N1 frame: start, data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Tx model: a frame is 10 bit times counted from the accepting edge, then a done cycle.
  logic       m_act, m_done;
  int         m_n;
  logic [7:0] m_byte;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_n    <= 0;
    end else if (!txEn) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
    end else if (m_act) begin
      if (m_n == 10 * TxBit - 1) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
      end else begin
        m_n <= m_n + 1;
      end
    end else begin
      m_done <= 1'b0;
      if (txStart) begin
        m_act  <= 1'b1;
        m_n    <= 0;
        m_byte <= txIn;
      end
    end
  end

  // Rx model: queue of bytes that good frames must deliver, in order.
  logic [7:0] rx_q[$];
  logic [7:0] m_rx_last = 8'h00;

  always @(negedge clk) begin : cmp
    logic exp_out;
    exp_out = m_act ? frame_bit(m_byte, m_n / TxBit) : 1'b1;
    check("txOut", txOut, exp_out);
    check("txBusy", txBusy, m_act);
    check("txDone", txDone, m_done);
    if (!rst_n) begin
      m_rx_last = 8'h00;
    end else if (rxDone) begin
      if (rx_q.size() == 0) begin
        check("rxDone_unexpected", rxDone, 1'b0);
      end else begin
        m_rx_last = rx_q.pop_front();
        check("rxErr_at_done", rxErr, 1'b0);
      end
    end
    check("rxOut", rxOut, m_rx_last);
  end

  task automatic send_rx(input logic [7:0] b, input logic stop, input int bit_clks);
    rx_drv = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    rx_drv = stop;
    repeat (bit_clks) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic [9:0] exp_bits);
    @(negedge clk);
    #1 txIn = b;
    txStart = 1'b1;
    @(posedge clk);
    #1 txStart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? TxBit / 2 : TxBit) @(negedge clk);
      check($sformatf("tx_bit%0d", i), txOut, exp_bits[i]);
    end
    repeat (TxBit / 2) @(negedge clk);
    check("tx_done_early", txDone, 1'b0);
    check("tx_busy_last", txBusy, 1'b1);
    @(negedge clk);
    check("tx_done_12500", txDone, 1'b1);
    check("tx_busy_end", txBusy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rxBusy"}, rxBusy, 1'b0);
    check({tag, "_rxDone"}, rxDone, 1'b0);
    check({tag, "_rxErr"}, rxErr, 1'b0);
    check({tag, "_rxOut"}, rxOut, 8'h00);
    check({tag, "_txBusy"}, txBusy, 1'b0);
    check({tag, "_txDone"}, txDone, 1'b0);
    check({tag, "_txOut"}, txOut, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rxEn = 1'b1; txEn = 1'b1; txStart = 1'b0; txIn = 8'h00;
    rx_drv = 1'b1; loop = 1'b0;
    #1 check_reset_values("por");
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(negedge clk);

    // Start glitch of 192 clks (16 us) must not produce a frame.
    rx_drv = 1'b0;
    repeat (150) @(negedge clk);
    check("glitch_busy", rxBusy, 1'b1);
    repeat (42) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) @(negedge clk);
    check("glitch_idle", rxBusy, 1'b0);
    check("glitch_err", rxErr, 1'b0);

    // Reset in the middle of an rx frame and a tx frame.
    @(negedge clk);
    #1 txIn = 8'h5A;
    txStart = 1'b1;
    rx_drv = 1'b0;
    @(posedge clk);
    #1 txStart = 1'b0;
    repeat (4000) @(negedge clk);
    check("mid_rxBusy", rxBusy, 1'b1);
    check("mid_txBusy", txBusy, 1'b1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(negedge clk);

    // 0x56 received 3% slow while 0xC3 is transmitted.
    rx_q.push_back(8'h56);
    fork
      send_rx(8'h56, 1'b1, 1287);
      tx_frame(8'hC3, 10'b1110000110);
    join
    repeat (200) @(negedge clk);
    check("rx56_pending", rx_q.size(), 0);
    check("rx56_out", rxOut, 8'h56);
    check("rx56_err", rxErr, 1'b0);

    // 0xA5 with a low stop bit, 3% fast.
    send_rx(8'hA5, 1'b0, 1212);
    repeat (100) @(negedge clk);
    check("ferr_err", rxErr, 1'b1);
    check("ferr_out", rxOut, 8'h56);
    check("ferr_busy", rxBusy, 1'b0);

    rx_q.push_back(8'h3C);
    fork
      send_rx(8'h3C, 1'b1, 1212);
      begin
        repeat (700) @(negedge clk);
        check("rx3c_err_cleared", rxErr, 1'b0);
        check("rx3c_busy", rxBusy, 1'b1);
      end
    join
    repeat (200) @(negedge clk);
    check("rx3c_pending", rx_q.size(), 0);
    check("rx3c_out", rxOut, 8'h3C);
    check("rx3c_err", rxErr, 1'b0);

    // Loopback: 0x00 then 0xFF back-to-back with txStart held; txIn change mid-frame ignored.
    loop = 1'b1;
    rx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    @(negedge clk);
    #1 txIn = 8'h00;
    txStart = 1'b1;
    repeat (2000) @(negedge clk);
    txIn = 8'hFF;
    repeat (11000) @(negedge clk);
    txStart = 1'b0;
    repeat (12900) @(negedge clk);
    check("loop_pending", rx_q.size(), 0);
    check("loop_out", rxOut, 8'hFF);
    check("loop_err", rxErr, 1'b0);
    check("loop_tx_idle", txBusy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
